// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader that receives a program image over an 8N1 UART line,
//   packs byte pairs (high byte first) into 16-bit instruction words and
//   writes them sequentially into the instruction memory. The CPU core is
//   held in reset until the whole image has been written.
//
//   Image format: length byte L (1..DEPTH words), then 2*L data bytes.
//
// Ports
//   clk0        system clock, rising edge
//   reset       asynchronous active-high reset
//   uart_rx     serial input, idle high, asynchronous to clk0
//   imem_web0   instruction memory write enable, active-low (one cycle/word)
//   imem_addr0  instruction memory write address
//   imem_din0   instruction word being written
//   core_reset  active-high reset to the CPU core, released when load is done
//   load_done   high once the full image has been written
//   frame_err   sticky flag: bad stop bit or illegal length byte seen
module program_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned ADDR_W       = 6
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              imem_web0,
  output logic [ADDR_W-1:0] imem_addr0,
  output logic [15:0]       imem_din0,
  output logic              core_reset,
  output logic              load_done,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned WC_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [WC_W-1:0]   WC_ONE  = WC_W'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    WAIT_LEN,
    WAIT_HI,
    WAIT_LO,
    WRITE,
    DONE
  } ld_state_t;

  // Synchronizer and receiver state
  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_valid_q, byte_valid_d;

  // Loader state
  ld_state_t         ld_state_q, ld_state_d;
  logic [WC_W-1:0]   len_q, len_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              web_q, web_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic              core_reset_q, core_reset_d;
  logic              load_done_q, load_done_d;
  logic              frame_err_q, frame_err_d;

  logic [WC_W-1:0]   word_cnt_inc;

  assign word_cnt_inc = word_cnt_q + WC_ONE;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    ld_state_d   = ld_state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    web_d        = 1'b1;
    addr_d       = addr_q;
    din_d        = din_q;
    core_reset_d = core_reset_q;
    load_done_d  = load_done_q;
    frame_err_d  = frame_err_q;

    // UART receiver
    unique case (rx_state_q)
      RX_IDLE: begin
        // Edge detect rather than level: a line held low after a bad stop
        // bit must not restart reception.
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d  = '0;
          bit_idx_d = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d = '0;
          shift_d  = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
          end else if (ld_state_q != DONE) begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // Image loader; shift_q holds the received byte while byte_valid_q is high
    unique case (ld_state_q)
      WAIT_LEN: begin
        if (byte_valid_q) begin
          if (32'(shift_q) >= 32'd1 && 32'(shift_q) <= DEPTH) begin
            len_d      = WC_W'(shift_q);
            word_cnt_d = '0;
            ld_state_d = WAIT_HI;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      WAIT_HI: begin
        if (byte_valid_q) begin
          din_d[15:8] = shift_q;
          ld_state_d  = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (byte_valid_q) begin
          din_d[7:0] = shift_q;
          web_d      = 1'b0;
          ld_state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d     = addr_q + ADR_ONE;
        word_cnt_d = word_cnt_inc;
        if (word_cnt_inc == len_q) begin
          ld_state_d   = DONE;
          core_reset_d = 1'b0;
          load_done_d  = 1'b1;
        end else begin
          ld_state_d = WAIT_HI;
        end
      end
      DONE: begin
      end
      default: ld_state_d = WAIT_LEN;
    endcase
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      ld_state_q   <= WAIT_LEN;
      len_q        <= '0;
      word_cnt_q   <= '0;
      web_q        <= 1'b1;
      addr_q       <= '0;
      din_q        <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= uart_rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      ld_state_q   <= ld_state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      web_q        <= web_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign imem_web0  = web_q;
  assign imem_addr0 = addr_q;
  assign imem_din0  = din_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed bench for program_loader with CLKS_PER_BIT=4. Drives UART
//   frames, logs every write-enable cycle, and compares against
//   hand-computed expectations.
module tb_program_loader;

  localparam int unsigned CPB = 4;

  logic        clk0;
  logic        reset;
  logic        uart_rx;
  logic        imem_web0;
  logic [5:0]  imem_addr0;
  logic [15:0] imem_din0;
  logic        core_reset;
  logic        load_done;
  logic        frame_err;

  int checks;
  int errors;
  int web_viol;

  logic [5:0]  wr_addr_log[$];
  logic [15:0] wr_data_log[$];

  program_loader #(
    .CLKS_PER_BIT(CPB),
    .DEPTH(64),
    .ADDR_W(6)
  ) dut (
    .clk0(clk0),
    .reset(reset),
    .uart_rx(uart_rx),
    .imem_web0(imem_web0),
    .imem_addr0(imem_addr0),
    .imem_din0(imem_din0),
    .core_reset(core_reset),
    .load_done(load_done),
    .frame_err(frame_err)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  // Every low cycle of imem_web0 is one write
  always @(negedge clk0) begin
    if (imem_web0 == 1'b0) begin
      wr_addr_log.push_back(imem_addr0);
      wr_data_log.push_back(imem_din0);
      if (reset || load_done) web_viol++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk0);
    #1;
    reset = 1'b0;
    wr_addr_log.delete();
    wr_data_log.delete();
    repeat (2) @(posedge clk0);
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(posedge clk0);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk0);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    uart_rx = 1'b1;
    repeat (3) @(posedge clk0);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < 2000) begin
      @(posedge clk0);
      n++;
    end
    #1;
    check_val(tag, {31'd0, load_done}, 32'd1);
  endtask

  task automatic check_outputs_reset(input string tag);
    check_val({tag, "_web"}, {31'd0, imem_web0}, 32'd1);
    check_val({tag, "_addr"}, {26'd0, imem_addr0}, 32'd0);
    check_val({tag, "_din"}, {16'd0, imem_din0}, 32'd0);
    check_val({tag, "_core_rst"}, {31'd0, core_reset}, 32'd1);
    check_val({tag, "_done"}, {31'd0, load_done}, 32'd0);
    check_val({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    web_viol = 0;
    reset    = 1'b1;
    uart_rx  = 1'b1;
    #1;
    check_outputs_reset("por");
    do_reset();
    check_outputs_reset("rst");

    // Three-word image
    send_byte(8'd3, 1'b1);
    send_word(16'h1234);
    send_word(16'hABCD);
    send_word(16'h0001);
    wait_done("t1_done");
    check_val("t1_nwr", wr_addr_log.size(), 32'd3);
    if (wr_addr_log.size() == 3) begin
      check_val("t1_a0", {26'd0, wr_addr_log[0]}, 32'd0);
      check_val("t1_d0", {16'd0, wr_data_log[0]}, 32'h1234);
      check_val("t1_a1", {26'd0, wr_addr_log[1]}, 32'd1);
      check_val("t1_d1", {16'd0, wr_data_log[1]}, 32'hABCD);
      check_val("t1_a2", {26'd0, wr_addr_log[2]}, 32'd2);
      check_val("t1_d2", {16'd0, wr_data_log[2]}, 32'h0001);
    end
    check_val("t1_core_rst", {31'd0, core_reset}, 32'd0);
    check_val("t1_ferr", {31'd0, frame_err}, 32'd0);

    // Full-depth image, words equal to their index
    do_reset();
    send_byte(8'd64, 1'b1);
    for (int i = 0; i < 64; i++) send_word(16'(i));
    wait_done("t2_done");
    repeat (20) @(posedge clk0);
    #1;
    check_val("t2_nwr", wr_addr_log.size(), 32'd64);
    if (wr_addr_log.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        check_val($sformatf("t2_a%0d", i), {26'd0, wr_addr_log[i]}, 32'(i));
        check_val($sformatf("t2_d%0d", i), {16'd0, wr_data_log[i]}, 32'(i));
      end
    end
    check_val("t2_addr_wrap", {26'd0, imem_addr0}, 32'd0);
    check_val("t2_core_rst", {31'd0, core_reset}, 32'd0);

    // Illegal lengths, then a legal one-word image
    do_reset();
    send_byte(8'd0, 1'b1);
    repeat (4) @(posedge clk0);
    #1;
    check_val("t3_ferr_l0", {31'd0, frame_err}, 32'd1);
    send_byte(8'd65, 1'b1);
    repeat (4) @(posedge clk0);
    #1;
    check_val("t3_nwr_bad", wr_addr_log.size(), 32'd0);
    check_val("t3_done_bad", {31'd0, load_done}, 32'd0);
    send_byte(8'd1, 1'b1);
    send_word(16'hBEEF);
    wait_done("t3_done");
    check_val("t3_nwr", wr_addr_log.size(), 32'd1);
    if (wr_addr_log.size() == 1) begin
      check_val("t3_a0", {26'd0, wr_addr_log[0]}, 32'd0);
      check_val("t3_d0", {16'd0, wr_data_log[0]}, 32'hBEEF);
    end
    check_val("t3_ferr_sticky", {31'd0, frame_err}, 32'd1);

    // Bad stop bit on the high byte, then resend
    do_reset();
    send_byte(8'd1, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (4) @(posedge clk0);
    #1;
    check_val("t4_ferr", {31'd0, frame_err}, 32'd1);
    check_val("t4_nwr_bad", wr_addr_log.size(), 32'd0);
    send_word(16'h55AA);
    wait_done("t4_done");
    check_val("t4_nwr", wr_addr_log.size(), 32'd1);
    if (wr_addr_log.size() == 1) begin
      check_val("t4_a0", {26'd0, wr_addr_log[0]}, 32'd0);
      check_val("t4_d0", {16'd0, wr_data_log[0]}, 32'h55AA);
    end

    // One-cycle low glitch while idle
    do_reset();
    @(posedge clk0);
    #1;
    uart_rx = 1'b0;
    @(posedge clk0);
    #1;
    uart_rx = 1'b1;
    repeat (60) @(posedge clk0);
    #1;
    check_val("t5_ferr", {31'd0, frame_err}, 32'd0);
    check_val("t5_nwr", wr_addr_log.size(), 32'd0);
    check_val("t5_din", {16'd0, imem_din0}, 32'd0);

    // Reset mid-image, then a fresh two-word image, then extra bytes in DONE
    do_reset();
    send_byte(8'd2, 1'b1);
    send_word(16'h1122);
    repeat (4) @(posedge clk0);
    #1;
    check_val("t6_nwr_part", wr_addr_log.size(), 32'd1);
    check_val("t6_addr_part", {26'd0, imem_addr0}, 32'd1);
    uart_rx = 1'b0;
    repeat (10) @(posedge clk0);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_reset("t6_async");
    uart_rx = 1'b1;
    do_reset();
    send_byte(8'd2, 1'b1);
    send_word(16'h0A0B);
    send_word(16'h0C0D);
    wait_done("t6_done");
    check_val("t6_nwr", wr_addr_log.size(), 32'd2);
    if (wr_addr_log.size() == 2) begin
      check_val("t6_a0", {26'd0, wr_addr_log[0]}, 32'd0);
      check_val("t6_d0", {16'd0, wr_data_log[0]}, 32'h0A0B);
      check_val("t6_a1", {26'd0, wr_addr_log[1]}, 32'd1);
      check_val("t6_d1", {16'd0, wr_data_log[1]}, 32'h0C0D);
    end
    send_byte(8'd1, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b0);
    send_byte(8'h99, 1'b1);
    repeat (10) @(posedge clk0);
    #1;
    check_val("t6_nwr_done", wr_addr_log.size(), 32'd2);
    check_val("t6_addr_frozen", {26'd0, imem_addr0}, 32'd2);
    check_val("t6_din_frozen", {16'd0, imem_din0}, 32'h0C0D);
    check_val("t6_ferr_frozen", {31'd0, frame_err}, 32'd0);
    check_val("t6_done_held", {31'd0, load_done}, 32'd1);

    check_val("web_viol", 32'(web_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
